fft_bitrev_loader: RTL
======================

Name: fft_bitrev_loader

Overview:
- Upstream input stage of the shared-butterfly DIT FFT.
- Accepts a natural-order complex sample stream over a valid/ready handshake and writes each sample into the FFT working RAM at its bit-reversed address, which is the in-place input order the DIT core requires.
- After a full frame of N samples is in RAM, it pulses the FFT start and holds off new input until the core reports done.
- Short frames are zero-padded to N.

Parameters:
- N, 8192, FFT length; power of two, minimum 8.
- ADDR_WIDTH, 13, log2(N); RAM address width.
- DATA_WIDTH, 32, sample width: {re[DATA_WIDTH/2-1:0], im[DATA_WIDTH/2-1:0]}, two's complement.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  global enable; when low, in_ready=0 and all counters and state hold.
- in_valid  in  1  upstream sample valid.
- in_ready  out  1  loader can accept a sample this cycle.
- in_data  in  DATA_WIDTH  sample, natural order.
- in_last  in  1  marks the last sample of a frame; qualified by in_valid & in_ready.
- ram_wr_en  out  1  RAM write strobe.
- ram_wr_addr  out  ADDR_WIDTH  bit-reversed write address.
- ram_wr_data  out  DATA_WIDTH  write data.
- fft_start  out  1  one-cycle pulse; frame loaded, FFT may begin.
- fft_done  in  1  FFT core finished; RAM free for the next frame.
- busy  out  1  high from the first accepted sample until fft_done is seen.
- frame_err  out  1  sticky error flag; cleared when the next frame's first sample is accepted.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: in_ready=0, ram_wr_en=0, ram_wr_addr=0, ram_wr_data=0, fft_start=0, busy=0, frame_err=0, count=0, state=IDLE. rst overrides en.
- Reset mid-frame: the frame is discarded, no fft_start is issued, and in_ready is low in the cycle after reset deasserts.
- States:
  - IDLE: in_ready=en. The first accept moves to LOAD.
  - LOAD: in_ready=en.
  - PAD: in_ready=0.
  - START: in_ready=0; one cycle.
  - WAIT: in_ready=0.
- Accept: a sample is accepted at an edge where in_valid & in_ready.
  - The accept registers ram_wr_en=1, ram_wr_addr=bitrev(count), ram_wr_data=in_data; these are visible the next cycle, so write latency is 1 cycle.
  - count then increments.
  - Cycles without an accept drive ram_wr_en=0.
- bitrev: bit i of count maps to bit ADDR_WIDTH-1-i. For N=8: 0->0, 1->4, 2->2, 3->6, 4->1, 5->5, 6->3, 7->7.
- Full frame: the accept at count=N-1 goes to START.
  - If in_last was not high on that accept, frame_err is set.
  - fft_start is high for exactly one cycle, in the cycle after the final RAM write strobe.
  - The state then moves to WAIT and count resets to 0.
- Early last: in_last on an accept with count<N-1 goes to PAD and sets frame_err.
  - PAD writes data 0 to bitrev(count) for count = c+1 .. N-1, one write per cycle and only while en=1.
  - After the write at N-1, the state goes to START.
- Late last: samples beyond N are never accepted, because in_ready drops after the Nth accept. An in_last arriving in the next frame is not special-cased.
- WAIT: leaves on fft_done=1 and goes to IDLE. busy falls in the same cycle as that transition, and in_ready rises the following cycle if en=1.
- fft_done while in IDLE, LOAD or PAD: ignored.
- en low:
  - In LOAD or PAD: no writes, count frozen; resumes exactly where it stopped.
  - In START: the fft_start pulse is deferred until en=1.
  - In WAIT: fft_done is still sampled.
- Simultaneous accept and in_last at count=N-1: treated as a normal full frame with no error.
- Throughput: one sample per cycle at sustained in_valid=1.
  - Frame-to-frame gap is 2 cycles plus the FFT compute time.

Test Plan:
1. N=8, reset, then stream samples 0..7 with in_valid=1, in_last on sample 7 -> writes go to addresses 0,4,2,6,1,5,3,7 with data 0..7 on consecutive cycles; fft_start pulses once, 1 cycle after the last write; frame_err=0; in_ready=0 until fft_done.
2. N=8, in_valid toggled 1/0 every cycle -> the same address/data sequence, with ram_wr_en following the accept pattern; no duplicate or skipped writes.
3. N=8, in_last on sample 4 (count=4) -> addresses 0,4,2,6,1 written with data; then data 0 written to 5,3,7 in 3 consecutive cycles; fft_start follows; frame_err=1; frame_err clears on the next frame's first accept.
4. N=8, full frame without in_last -> fft_start issued, frame_err=1.
5. N=8, rst asserted after 3 accepts -> all outputs at reset values next cycle; no fft_start; the next frame starts writing at address 0.
6. N=8192, full ramp 0..8191 -> sample 1 written to address 4096, sample 8191 to 8191; exactly 8192 writes; one fft_start; fft_done pulse returns the loader to IDLE with in_ready=1 the next cycle.

Source files
------------

// File: rtl/fft_bitrev_loader_if.sv
// Sample stream, FFT RAM write port and FFT control handshake between
// upstream, the bit-reversal loader and the FFT core.
interface fft_bitrev_loader_if #(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32
);
   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_last;
   logic                  ram_wr_en;
   logic [ADDR_WIDTH-1:0] ram_wr_addr;
   logic [DATA_WIDTH-1:0] ram_wr_data;
   logic                  fft_start;
   logic                  fft_done;
   logic                  busy;
   logic                  frame_err;

   modport master (
      output in_valid, in_data, in_last, fft_done,
      input  in_ready, ram_wr_en, ram_wr_addr, ram_wr_data, fft_start, busy, frame_err
   );

   modport slave (
      input  in_valid, in_data, in_last, fft_done,
      output in_ready, ram_wr_en, ram_wr_addr, ram_wr_data, fft_start, busy, frame_err
   );
endinterface

// File: rtl/fft_bitrev_loader.sv
// Loads a natural-order sample frame into the FFT RAM at bit-reversed
// addresses, zero-pads short frames, then starts the FFT and waits for done.
module fft_bitrev_loader #(
   parameter int N          = 8192,
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   fft_bitrev_loader_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD, PAD, START, WAIT} state_t;

   state_t                state, state_d;
   logic [ADDR_WIDTH-1:0] count, count_d;
   logic                  wr_en_q, wr_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                  start_q, start_d;
   logic                  busy_q, busy_d;
   logic                  err_q, err_d;
   // Held low for one cycle after reset so in_ready cannot rise the
   // very cycle reset is released.
   logic                  armed;
   logic                  accept;
   logic                  last_idx;

   function automatic logic [ADDR_WIDTH-1:0] bitrev(input logic [ADDR_WIDTH-1:0] v);
      logic [ADDR_WIDTH-1:0] r;
      for (int i = 0; i < ADDR_WIDTH; i++) r[ADDR_WIDTH-1-i] = v[i];
      return r;
   endfunction

   assign last_idx        = (count == ADDR_WIDTH'(N-1));
   assign bus.in_ready    = ~rst & armed & en & ((state == IDLE) || (state == LOAD));
   assign accept          = bus.in_valid & bus.in_ready;
   assign bus.ram_wr_en   = wr_en_q;
   assign bus.ram_wr_addr = wr_addr_q;
   assign bus.ram_wr_data = wr_data_q;
   assign bus.fft_start   = start_q;
   assign bus.busy        = busy_q;
   assign bus.frame_err   = err_q;

   always_comb begin
      state_d   = state;
      count_d   = count;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      start_d   = 1'b0;
      busy_d    = busy_q;
      err_d     = err_q;
      case (state)
         IDLE, LOAD: begin
            if (accept) begin
               wr_en_d   = 1'b1;
               wr_addr_d = bitrev(count);
               wr_data_d = bus.in_data;
               count_d   = count + 1'b1;
               busy_d    = 1'b1;
               if (state == IDLE) err_d = 1'b0;
               if (last_idx) begin
                  state_d = START;
                  if (!bus.in_last) err_d = 1'b1;
               end else if (bus.in_last) begin
                  state_d = PAD;
                  err_d   = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end
         end
         PAD: begin
            if (en) begin
               wr_en_d   = 1'b1;
               wr_addr_d = bitrev(count);
               wr_data_d = '0;
               count_d   = count + 1'b1;
               if (last_idx) state_d = START;
            end
         end
         START: begin
            if (en) begin
               start_d = 1'b1;
               count_d = '0;
               state_d = WAIT;
            end
         end
         WAIT: begin
            // fft_done is honoured regardless of en
            if (bus.fft_done) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         count     <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         armed     <= 1'b0;
      end else begin
         state     <= state_d;
         count     <= count_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         start_q   <= start_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         armed     <= 1'b1;
      end
   end
endmodule
